// File: rtl/mult_bank_arbiter_if.sv
// Requester-side bundle of the multiplier-bank arbiter: operation requests
// and operands in, grants and broadcast results out.
interface mult_bank_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int LANES   = 9,
   parameter int WIDTH   = 27
);
   logic [NUM_REQ-1:0]                         req;
   logic [NUM_REQ-1:0]                         req_lock;
   logic [NUM_REQ-1:0][LANES-1:0][WIDTH-1:0]   req_dataa;
   logic [NUM_REQ-1:0][LANES-1:0][WIDTH-1:0]   req_datab;
   logic [NUM_REQ-1:0]                         gnt;
   logic [NUM_REQ-1:0]                         rsp_valid;
   logic [LANES-1:0][WIDTH-1:0]                rsp_data;
   logic                                       busy;

   modport master (
      output req, req_lock, req_dataa, req_datab,
      input  gnt, rsp_valid, rsp_data, busy
   );

   modport slave (
      input  req, req_lock, req_dataa, req_datab,
      output gnt, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/mult_bank_arbiter.sv
// Round-robin arbiter with burst lock sharing one multiplier bank; a tag
// pipeline matched to the bank latency routes each result to its issuer.
module mult_bank_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int LANES        = 9,
   parameter int WIDTH        = 27,
   parameter int MULT_LATENCY = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   mult_bank_arbiter_if.slave            req_bus,
   output logic [LANES-1:0][WIDTH-1:0]   array_mult_dataa,
   output logic [LANES-1:0][WIDTH-1:0]   array_mult_datab,
   input  logic [LANES-1:0][WIDTH-1:0]   array_mult_result
);
   localparam int ID_W = $clog2(NUM_REQ);
   localparam int LAST = MULT_LATENCY - 1;

   typedef logic [LANES-1:0][WIDTH-1:0] lanes_t;
   typedef enum logic {ARB_RR, ARB_LOCKED} arb_state_t;

   arb_state_t           state_reg, state_next;
   logic [ID_W-1:0]      ptr_reg, ptr_next;
   logic [ID_W-1:0]      lock_owner_reg, lock_owner_next;
   logic [NUM_REQ-1:0]   gnt;
   logic [ID_W-1:0]      gnt_id;
   logic                 issue;
   logic                 lock_hold;
   logic                 rr_found;
   logic [ID_W:0]        rr_sum;

   logic                 tag_valid_reg [MULT_LATENCY];
   logic [ID_W-1:0]      tag_id_reg    [MULT_LATENCY];
   logic                 busy_acc      [MULT_LATENCY+1];
   lanes_t               acc_a         [NUM_REQ+1];
   lanes_t               acc_b         [NUM_REQ+1];
   logic [NUM_REQ-1:0]   rsp_valid_reg;
   logic [NUM_REQ-1:0]   rsp_onehot;
   lanes_t               rsp_data_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ARB_RR;
         ptr_reg        <= '0;
         lock_owner_reg <= '0;
      end else begin
         state_reg      <= state_next;
         ptr_reg        <= ptr_next;
         lock_owner_reg <= lock_owner_next;
      end
   end

   // A held lock wins; otherwise search from ptr. A dropped lock owner falls
   // back to round-robin in the same cycle so no bubble is inserted.
   always_comb begin
      gnt             = '0;
      gnt_id          = '0;
      rr_found        = 1'b0;
      rr_sum          = '0;
      state_next      = state_reg;
      ptr_next        = ptr_reg;
      lock_owner_next = lock_owner_reg;
      lock_hold       = (state_reg == ARB_LOCKED) && req_bus.req[lock_owner_reg];
      if (!rst && en) begin
         if (lock_hold) begin
            gnt[lock_owner_reg] = 1'b1;
            gnt_id              = lock_owner_reg;
         end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
               rr_sum = {1'b0, ptr_reg} + (ID_W+1)'(k);
               if (rr_sum >= (ID_W+1)'(NUM_REQ)) begin
                  rr_sum = rr_sum - (ID_W+1)'(NUM_REQ);
               end
               if (!rr_found && req_bus.req[rr_sum[ID_W-1:0]]) begin
                  rr_found                 = 1'b1;
                  gnt[rr_sum[ID_W-1:0]]    = 1'b1;
                  gnt_id                   = rr_sum[ID_W-1:0];
               end
            end
         end
         if (|gnt) begin
            if (req_bus.req_lock[gnt_id]) begin
               state_next      = ARB_LOCKED;
               lock_owner_next = gnt_id;
            end else begin
               state_next = ARB_RR;
               ptr_next   = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
            end
         end else if (state_reg == ARB_LOCKED && !lock_hold) begin
            state_next = ARB_RR;
         end
      end
   end

   assign issue = |gnt;

   assign acc_a[0] = '0;
   assign acc_b[0] = '0;
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_opmux
         assign acc_a[gi+1] = acc_a[gi] | (gnt[gi] ? req_bus.req_dataa[gi] : lanes_t'(0));
         assign acc_b[gi+1] = acc_b[gi] | (gnt[gi] ? req_bus.req_datab[gi] : lanes_t'(0));
      end
   endgenerate
   assign array_mult_dataa = acc_a[NUM_REQ];
   assign array_mult_datab = acc_b[NUM_REQ];

   // Tags advance every cycle, independent of en, so responses never stall.
   assign busy_acc[0] = 1'b0;
   generate
      for (genvar gi = 0; gi < MULT_LATENCY; gi++) begin : g_tag
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (rst) begin
                  tag_valid_reg[gi] <= 1'b0;
                  tag_id_reg[gi]    <= '0;
               end else begin
                  tag_valid_reg[gi] <= issue;
                  tag_id_reg[gi]    <= gnt_id;
               end
            end
         end else begin : g_shift
            always_ff @(posedge clk) begin
               if (rst) begin
                  tag_valid_reg[gi] <= 1'b0;
                  tag_id_reg[gi]    <= '0;
               end else begin
                  tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                  tag_id_reg[gi]    <= tag_id_reg[gi-1];
               end
            end
         end
         assign busy_acc[gi+1] = busy_acc[gi] | tag_valid_reg[gi];
      end
   endgenerate

   always_comb begin
      rsp_onehot                   = '0;
      rsp_onehot[tag_id_reg[LAST]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
      end else begin
         rsp_valid_reg <= tag_valid_reg[LAST] ? rsp_onehot : '0;
         if (tag_valid_reg[LAST]) begin
            rsp_data_reg <= array_mult_result;
         end
      end
   end

   assign req_bus.gnt       = gnt;
   assign req_bus.rsp_valid = rsp_valid_reg;
   assign req_bus.rsp_data  = rsp_data_reg;
   assign req_bus.busy      = busy_acc[MULT_LATENCY];
endmodule
